// File: rtl/rk05_pkg.sv
// Shared types and constants for the DRAM access arbiter.
// Grant codes double as the requester identifiers.
package rk05_pkg;

    localparam logic [1:0] GNT_NONE  = 2'd0;
    localparam logic [1:0] GNT_BUSRD = 2'd1;
    localparam logic [1:0] GNT_BUSWR = 2'd2;
    localparam logic [1:0] GNT_SPI   = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        DONE
    } arb_state_t;

    localparam logic [15:0] TIMEOUT_READ_DATA = 16'hFFFF;

endpackage

// File: rtl/arb_priority_select.sv
// Combinational winner pick: bus read > bus write > SPI,
// except that a starved SPI request jumps the queue.
module arb_priority_select
    import rk05_pkg::*;
(
    input  logic       busrd_req,
    input  logic       buswr_req,
    input  logic       spi_req,
    input  logic       spi_starved,
    output logic [1:0] winner
);

    always_comb begin
        winner = GNT_NONE;
        if (spi_req && spi_starved)
            winner = GNT_SPI;
        else if (busrd_req)
            winner = GNT_BUSRD;
        else if (buswr_req)
            winner = GNT_BUSWR;
        else if (spi_req)
            winner = GNT_SPI;
    end

endmodule

// File: rtl/dram_access_arbiter.sv
// Shares the sdram_controller port between SPI, bus read
// and bus write using four-phase req/ack handshakes.
module dram_access_arbiter
    import rk05_pkg::*;
#(
    parameter int TIMEOUT_CYCLES   = 64,
    parameter int SPI_STARVE_LIMIT = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        spi_req,
    input  logic        spi_we,
    input  logic [15:0] spi_wdata,
    output logic        spi_ack,
    output logic [15:0] spi_rdata,
    input  logic        busrd_req,
    output logic        busrd_ack,
    output logic [15:0] busrd_rdata,
    input  logic        buswr_req,
    input  logic [15:0] buswr_wdata,
    output logic        buswr_ack,
    output logic        ctl_read_enbl,
    output logic        ctl_write_enbl,
    output logic [15:0] ctl_writedata,
    input  logic [15:0] ctl_readdata,
    input  logic        ctl_readack,
    input  logic        ctl_writeack,
    output logic [1:0]  grant,
    output logic        timeout_err
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ?
                        $clog2(TIMEOUT_CYCLES) : 1;
    localparam int SW = (SPI_STARVE_LIMIT > 0) ?
                        $clog2(SPI_STARVE_LIMIT + 1) : 1;

    arb_state_t      state;
    arb_state_t      state_nxt;
    logic [1:0]      winner;
    logic            starved;
    logic            take;
    logic            take_wr;
    logic            op_wr;
    logic            cmp_hit;
    logic            to_hit;
    logic            rd_done;
    logic            gnt_req;
    logic [15:0]     rd_val;
    logic [TW-1:0]   wait_cnt;
    logic [SW-1:0]   starve_cnt;

    assign starved = spi_req &&
                     (starve_cnt == SW'(SPI_STARVE_LIMIT));

    arb_priority_select u_sel (
        .busrd_req   (busrd_req),
        .buswr_req   (buswr_req),
        .spi_req     (spi_req),
        .spi_starved (starved),
        .winner      (winner)
    );

    assign take    = (state == IDLE) && (winner != GNT_NONE);
    assign take_wr = (winner == GNT_BUSWR) ||
                     ((winner == GNT_SPI) && spi_we);

    // Only the ack matching the issued direction completes.
    assign cmp_hit = op_wr ? ctl_writeack : ctl_readack;
    assign to_hit  = (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign rd_done = (state == WAIT_ACK) && !op_wr &&
                     (ctl_readack || to_hit);
    assign rd_val  = ctl_readack ? ctl_readdata
                                 : TIMEOUT_READ_DATA;

    always_comb begin
        gnt_req = 1'b0;
        unique case (1'b1)
            grant == GNT_BUSRD: gnt_req = busrd_req;
            grant == GNT_BUSWR: gnt_req = buswr_req;
            grant == GNT_SPI:   gnt_req = spi_req;
            default:            gnt_req = 1'b0;
        endcase
    end

    assign busrd_ack = (state == DONE) && (grant == GNT_BUSRD);
    assign buswr_ack = (state == DONE) && (grant == GNT_BUSWR);
    assign spi_ack   = (state == DONE) && (grant == GNT_SPI);

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (take) state_nxt = ISSUE;
            ISSUE:    state_nxt = WAIT_ACK;
            WAIT_ACK: if (cmp_hit || to_hit)
                          state_nxt = DONE;
            DONE:     if (!gnt_req) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            grant          <= GNT_NONE;
            ctl_read_enbl  <= 1'b0;
            ctl_write_enbl <= 1'b0;
            ctl_writedata  <= '0;
            op_wr          <= 1'b0;
            wait_cnt       <= '0;
            starve_cnt     <= '0;
            timeout_err    <= 1'b0;
            spi_rdata      <= '0;
            busrd_rdata    <= '0;
        end else begin
            ctl_read_enbl  <= 1'b0;
            ctl_write_enbl <= 1'b0;
            if (take) begin
                grant          <= winner;
                op_wr          <= take_wr;
                ctl_read_enbl  <= !take_wr;
                ctl_write_enbl <= take_wr;
                wait_cnt       <= '0;
                if (winner == GNT_BUSWR)
                    ctl_writedata <= buswr_wdata;
                else if (winner == GNT_SPI)
                    ctl_writedata <= spi_wdata;
                // Only bus grants made over a waiting SPI count.
                if (winner == GNT_SPI || !spi_req)
                    starve_cnt <= '0;
                else
                    starve_cnt <= starve_cnt + 1'b1;
            end
            if (state == WAIT_ACK) begin
                wait_cnt <= wait_cnt + 1'b1;
                if (!cmp_hit && to_hit)
                    timeout_err <= 1'b1;
            end
            if (rd_done) begin
                if (grant == GNT_SPI)
                    spi_rdata <= rd_val;
                else
                    busrd_rdata <= rd_val;
            end
            if (state == DONE && !gnt_req)
                grant <= GNT_NONE;
        end
    end

endmodule

// File: tb/tb_dram_access_arbiter.sv
// Scoreboard bench for dram_access_arbiter with a
// behavioural controller that acks after a set delay.
module tb_dram_access_arbiter;
    import rk05_pkg::*;

    localparam int TO = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic        spi_req, spi_we;
    logic [15:0] spi_wdata;
    logic        spi_ack;
    logic [15:0] spi_rdata;
    logic        busrd_req, busrd_ack;
    logic [15:0] busrd_rdata;
    logic        buswr_req, buswr_ack;
    logic [15:0] buswr_wdata;
    logic        ctl_read_enbl, ctl_write_enbl;
    logic [15:0] ctl_writedata;
    logic [15:0] ctl_readdata;
    logic        ctl_readack, ctl_writeack;
    logic [1:0]  grant;
    logic        timeout_err;

    dram_access_arbiter #(
        .TIMEOUT_CYCLES   (TO),
        .SPI_STARVE_LIMIT (2)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .spi_req        (spi_req),
        .spi_we         (spi_we),
        .spi_wdata      (spi_wdata),
        .spi_ack        (spi_ack),
        .spi_rdata      (spi_rdata),
        .busrd_req      (busrd_req),
        .busrd_ack      (busrd_ack),
        .busrd_rdata    (busrd_rdata),
        .buswr_req      (buswr_req),
        .buswr_wdata    (buswr_wdata),
        .buswr_ack      (buswr_ack),
        .ctl_read_enbl  (ctl_read_enbl),
        .ctl_write_enbl (ctl_write_enbl),
        .ctl_writedata  (ctl_writedata),
        .ctl_readdata   (ctl_readdata),
        .ctl_readack    (ctl_readack),
        .ctl_writeack   (ctl_writeack),
        .grant          (grant),
        .timeout_err    (timeout_err)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  gnt;
        logic [15:0] rd;
        bit          chk_rd;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t mk(input logic [1:0] g,
                                input logic [15:0] r,
                                input bit c);
        exp_t e;
        e.gnt = g;
        e.rd = r;
        e.chk_rd = c;
        return e;
    endfunction

    function automatic logic [2:0] ack_bit(input logic [1:0] g);
        logic [2:0] b;
        b = 3'b000;
        if (g == GNT_BUSRD) b = 3'b001;
        if (g == GNT_BUSWR) b = 3'b010;
        if (g == GNT_SPI)   b = 3'b100;
        return b;
    endfunction

    // Controller model: ack ctl_k cycles after the enable.
    int          ctl_k = 1;
    bit          ctl_never = 0;
    bit          ctl_spur = 0;
    logic [15:0] ctl_val = 16'h0;
    bit          c_pend = 0;
    bit          c_pwr = 0;
    int          c_age = 0;

    always @(negedge clock) begin
        ctl_readack = 1'b0;
        ctl_writeack = 1'b0;
        ctl_readdata = 16'hDEAD;
        if (reset) begin
            c_pend = 0;
        end else begin
            if (c_pend) begin
                c_age++;
                if (ctl_spur && !c_pwr && c_age == 1)
                    ctl_writeack = 1'b1;
                if (!ctl_never && c_age == ctl_k) begin
                    if (c_pwr) begin
                        ctl_writeack = 1'b1;
                    end else begin
                        ctl_readack = 1'b1;
                        ctl_readdata = ctl_val;
                    end
                    c_pend = 0;
                end
            end
            if (ctl_read_enbl || ctl_write_enbl) begin
                c_pend = 1;
                c_age = 0;
                c_pwr = ctl_write_enbl;
            end
        end
    end

    // Monitor: pops the scoreboard on each requester ack rise.
    int          ncyc = 0;
    int          en_t = 0;
    int          en_cnt = 0;
    int          last_lat = 0;
    logic [15:0] last_wd = 16'h0;
    logic        last_wen = 1'b0;
    logic [2:0]  prev_acks = 3'b000;

    always @(negedge clock) begin
        logic [2:0] acks;
        logic [2:0] rise;
        exp_t       e;
        ncyc++;
        acks = {spi_ack, buswr_ack, busrd_ack};
        rise = acks & ~prev_acks;
        if (ctl_read_enbl || ctl_write_enbl) begin
            en_t = ncyc;
            en_cnt++;
            last_wd = ctl_writedata;
            last_wen = ctl_write_enbl;
        end
        if (!reset && rise != 3'b000) begin
            last_lat = ncyc - en_t;
            if (sb.size() == 0) begin
                chk("sb_empty", 32'(rise), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_gnt", 32'(grant), 32'(e.gnt));
                chk("sb_who", 32'(rise), 32'(ack_bit(e.gnt)));
                if (e.chk_rd)
                    chk("sb_rdata",
                        32'(e.gnt == GNT_SPI ? spi_rdata
                                             : busrd_rdata),
                        32'(e.rd));
            end
        end
        prev_acks = acks;
    end

    function automatic logic ack_of(input logic [1:0] who);
        if (who == GNT_BUSRD) return busrd_ack;
        if (who == GNT_BUSWR) return buswr_ack;
        return spi_ack;
    endfunction

    task automatic set_req(input logic [1:0] who,
                           input logic v);
        if (who == GNT_BUSRD) busrd_req = v;
        else if (who == GNT_BUSWR) buswr_req = v;
        else spi_req = v;
    endtask

    task automatic wait_for(input logic [1:0] who,
                            input logic lvl,
                            input int lim,
                            input string tag);
        for (int i = 0; i < lim; i++) begin
            @(negedge clock);
            if (ack_of(who) == lvl) return;
        end
        chk(tag, 32'(ack_of(who)), 32'(lvl));
    endtask

    task automatic serve(input logic [1:0] who,
                         input logic we,
                         input logic [15:0] wd,
                         input int lim);
        if (who == GNT_BUSWR) buswr_wdata = wd;
        if (who == GNT_SPI) begin
            spi_we = we;
            spi_wdata = wd;
        end
        set_req(who, 1'b1);
        wait_for(who, 1'b1, lim, "ack_rise");
        set_req(who, 1'b0);
        wait_for(who, 1'b0, 1, "ack_fall");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got hang want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        spi_req = 1'b1;
        busrd_req = 1'b1;
        buswr_req = 1'b1;
        spi_we = 1'b1;
        spi_wdata = 16'h1111;
        buswr_wdata = 16'h2222;
        repeat (3) @(negedge clock);
        chk("rst_gnt", 32'(grant), 32'd0);
        chk("rst_en", 32'({ctl_read_enbl, ctl_write_enbl}), 0);
        chk("rst_ack",
            32'({spi_ack, busrd_ack, buswr_ack}), 0);
        chk("rst_rd", {spi_rdata, busrd_rdata}, 0);
        chk("rst_wd", 32'(ctl_writedata), 0);
        chk("rst_to", 32'(timeout_err), 0);

        // First grant after reset goes to bus read.
        ctl_k = 1;
        ctl_val = 16'h1111;
        sb.push_back(mk(GNT_BUSRD, 16'h1111, 1));
        reset = 1'b0;
        @(negedge clock);
        chk("first_gnt", 32'(grant), 32'(GNT_BUSRD));
        chk("first_ren", 32'(ctl_read_enbl), 1);
        chk("first_wen", 32'(ctl_write_enbl), 0);
        spi_req = 1'b0;
        buswr_req = 1'b0;
        @(negedge clock);
        chk("ren_pulse", 32'(ctl_read_enbl), 0);
        wait_for(GNT_BUSRD, 1'b1, 10, "first_ack");
        busrd_req = 1'b0;
        wait_for(GNT_BUSRD, 1'b0, 1, "first_fall");
        chk("first_lat", 32'(last_lat), 32'd2);

        // SPI write, writeack two cycles after the enable.
        ctl_k = 2;
        sb.push_back(mk(GNT_SPI, 16'h0000, 1));
        serve(GNT_SPI, 1'b1, 16'hA5C3, 20);
        chk("spiw_lat", 32'(last_lat), 32'd3);
        chk("spiw_wd", 32'(last_wd), 32'h0000A5C3);
        chk("spiw_wen", 32'(last_wen), 1);

        // Starvation: bus read and SPI read held together.
        ctl_k = 1;
        ctl_val = 16'h1234;
        sb.push_back(mk(GNT_BUSRD, 16'h1234, 1));
        sb.push_back(mk(GNT_BUSRD, 16'h1234, 1));
        sb.push_back(mk(GNT_SPI, 16'h1234, 1));
        sb.push_back(mk(GNT_BUSRD, 16'h1234, 1));
        fork
            begin
                repeat (3) serve(GNT_BUSRD, 1'b0, 16'h0, 30);
            end
            serve(GNT_SPI, 1'b0, 16'h0, 40);
        join

        // Bus write never acked: forced completion.
        ctl_never = 1;
        chk("to_pre", 32'(timeout_err), 0);
        sb.push_back(mk(GNT_BUSWR, 16'h0, 0));
        serve(GNT_BUSWR, 1'b1, 16'hBEEF, 200);
        chk("to_lat", 32'(last_lat), 32'(TO + 1));
        chk("to_err", 32'(timeout_err), 1);
        chk("to_wd", 32'(last_wd), 32'h0000BEEF);

        // Timed-out read returns all ones.
        sb.push_back(mk(GNT_SPI, 16'hFFFF, 1));
        serve(GNT_SPI, 1'b0, 16'h0, 200);

        ctl_never = 0;
        ctl_val = 16'h5A5A;
        sb.push_back(mk(GNT_BUSRD, 16'h5A5A, 1));
        serve(GNT_BUSRD, 1'b0, 16'h0, 20);
        chk("to_sticky", 32'(timeout_err), 1);

        // Spurious writeack during a read is ignored.
        ctl_k = 3;
        ctl_spur = 1;
        ctl_val = 16'h0F0F;
        sb.push_back(mk(GNT_BUSRD, 16'h0F0F, 1));
        serve(GNT_BUSRD, 1'b0, 16'h0, 20);
        chk("spur_lat", 32'(last_lat), 32'd4);
        chk("spur_spi", 32'(spi_rdata), 32'h0000FFFF);
        ctl_spur = 0;

        // Reset while waiting for the controller.
        ctl_never = 1;
        buswr_wdata = 16'h3C3C;
        buswr_req = 1'b1;
        @(negedge clock);
        chk("mid_wen", 32'(ctl_write_enbl), 1);
        repeat (2) @(negedge clock);
        chk("mid_gnt", 32'(grant), 32'(GNT_BUSWR));
        reset = 1'b1;
        buswr_req = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        chk("mid_rst_gnt", 32'(grant), 0);
        chk("mid_rst_to", 32'(timeout_err), 0);
        chk("mid_rst_rd", {spi_rdata, busrd_rdata}, 0);
        begin
            int en0;
            en0 = en_cnt;
            repeat (6) @(negedge clock);
            chk("mid_quiet_en", 32'(en_cnt - en0), 0);
            chk("mid_quiet_ack",
                32'({spi_ack, busrd_ack, buswr_ack}), 0);
        end
        ctl_never = 0;
        ctl_k = 1;
        ctl_val = 16'h7777;
        sb.push_back(mk(GNT_BUSRD, 16'h7777, 1));
        serve(GNT_BUSRD, 1'b0, 16'h0, 20);
        chk("post_lat", 32'(last_lat), 32'd2);

        repeat (3) @(negedge clock);
        chk("sb_drain", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks",
                 n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/dram_access_arbiter.md
# dram_access_arbiter

Shares the single `sdram_controller` data port between three requesters: SPI (host load/unload), bus read, and bus write. Requesters use a four-phase request/acknowledge handshake. The arbiter issues one-cycle read or write enable pulses to the controller, waits for the controller's `dram_readack`/`dram_writeack`, and returns captured read data to the winning requester. It sits between the SPI/bus interface blocks and `sdram_controller`. It replaces the direct OR-ing of enables, which is only safe when requesters never overlap.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64: cycles allowed in WAIT_ACK before forced completion.
- `SPI_STARVE_LIMIT`, default 2: consecutive bus grants allowed while SPI is pending.

Ports:
- `clock` in 1: master clock, 40 MHz. This is the only clock.
- `reset` in 1: synchronous, active-high reset.
- `spi_req` in 1, `spi_we` in 1, `spi_wdata` in 16: SPI request, direction (1 = write), and write data.
- `spi_ack` out 1, `spi_rdata` out 16: SPI acknowledge and read data.
- `busrd_req` in 1: bus read request.
- `busrd_ack` out 1, `busrd_rdata` out 16: bus read acknowledge and read data.
- `buswr_req` in 1, `buswr_wdata` in 16: bus write request and write data.
- `buswr_ack` out 1: bus write acknowledge.
- `ctl_read_enbl` out 1, `ctl_write_enbl` out 1, `ctl_writedata` out 16: to the controller.
- `ctl_readdata` in 16, `ctl_readack` in 1, `ctl_writeack` in 1: from the controller.
- `grant` out 2: 0 = none, 1 = bus read, 2 = bus write, 3 = SPI.
- `timeout_err` out 1: sticky; cleared only by reset.

## Operation
States:
- IDLE → ISSUE when any request is high.
- ISSUE → WAIT_ACK unconditionally.
- WAIT_ACK → DONE on the matching ack, or on timeout.
- DONE → IDLE when the granted requester's req is low.

Arbitration:
- Priority is sampled only in IDLE: bus read > bus write > SPI.
- A starvation counter increments on each bus grant taken while `spi_req` is high. It clears on an SPI grant, or on any grant taken while `spi_req` is low.
- When the counter equals `SPI_STARVE_LIMIT` and `spi_req` is high, SPI wins.

Issue and completion:
- ISSUE drives exactly one enable for one cycle: read for bus read, write for bus write, or the value of `spi_we` for SPI.
- `ctl_writedata` is latched in IDLE→ISSUE from the winner's wdata. It holds until the next grant.
- A read completes only on `ctl_readack`; a write completes only on `ctl_writeack`. The non-matching ack is ignored.
- On `ctl_readack`, `ctl_readdata` is captured into the winner's rdata register. Rdata registers hold their value until the next read by the same requester.

Handshake:
- The winner's ack is high throughout DONE.
- The requester must hold req and wdata stable until ack, then drop req. Ack falls the cycle after req is seen low.
- A request dropped before it is granted is simply not served.
- A request dropped while the grant is active completes normally, and DONE exits immediately.

Timeout:
- The WAIT_ACK counter reaches `TIMEOUT_CYCLES` → DONE, `timeout_err` is set, and a read returns 16'hFFFF.

Reset:
- Reset takes priority over everything. A reset mid-operation returns to IDLE with no further enable pulses.
- All outputs are zero after reset: acks, enables, `grant`, `timeout_err`, rdata registers, `ctl_writedata`, and the starvation counter.

## Timing
- Request high at edge N (in IDLE) → `grant` and enable high at N+1. Enables are registered outputs with no combinational path from req.
- Controller ack at N+1+k (k ≥ 1) → requester ack and rdata valid at N+2+k.
- Minimum req-to-ack latency is 3 cycles.
- Back-to-back: requester drops req at M → ack low at M+1 (IDLE) → the next grant can occur at M+2.
- Simultaneous requests: one grant per pass through IDLE; losers remain pending.
- Acks arriving outside WAIT_ACK are ignored.
- Worst-case time held by one requester: 3 + `TIMEOUT_CYCLES` cycles.

## Structure
- Package `rk05_pkg`:
  - grant encoding constants: `GNT_NONE`, `GNT_BUSRD`, `GNT_BUSWR`, `GNT_SPI`;
  - state enum `arb_state_t`: IDLE, ISSUE, WAIT_ACK, DONE;
  - `TIMEOUT_READ_DATA` = 16'hFFFF.
- One sub-module, `arb_priority_select`: combinational winner selection from the three requests plus the starvation flag.
- The FSM, counters, and data registers stay in the top module.

## Test plan
- Reset with all requests high → all outputs 0. After reset is released, the first grant is bus read; `ctl_read_enbl` pulses for exactly 1 cycle.
- SPI write of 16'hA5C3, controller writeack 2 cycles after the enable → `ctl_writedata` = A5C3, `spi_ack` high at enable+3, `spi_rdata` unchanged.
- Bus read and SPI read held continuously, controller returns 16'h1234 each time → grant order BUSRD, BUSRD, SPI, BUSRD (limit 2); `busrd_rdata` = 1234.
- Controller never acks a bus-write request → after 64 WAIT_ACK cycles, `buswr_ack` rises and `timeout_err` is set. It stays set through later traffic.
- Spurious `ctl_writeack` during a read, then readack with 16'h0F0F → no early completion; `busrd_rdata` = 0F0F.
- Reset asserted in WAIT_ACK → IDLE the next cycle, no acks or enables until a fresh request arrives.
